// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, FSM state type and digit patterns for the score display
// Contents: DIGITS, SEG_BLANK, state_t, seg_pattern() (BCD digit -> active-low g..a pattern).
package seg7_pkg;

    localparam int unsigned DIGITS    = 4;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_COMMIT
    } state_t;

    // Bit order g..a, active-low; non-decimal codes fall back to blank.
    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/score_seg_display_if.sv
// rtl/score_seg_display_if.sv - score update channel between game core and display stage
// Signals: score (binary score), score_valid (single-cycle strobe), busy (conversion in flight).
// Modports: master = score source, slave = display stage.
interface score_if #(
    parameter int SCORE_W = 14
);
    logic [SCORE_W-1:0] score;
    logic               score_valid;
    logic               busy;

    modport master (output score, output score_valid, input busy);
    modport slave  (input score, input score_valid, output busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to 4-digit BCD converter
// Ports: clk, clr_n (async active-low), start (load bin), bin (operand, <= 9999),
//        done (high during the final iteration cycle), bcd (result, stable once done).
module bin2bcd_seq #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         done,
    output logic [15:0]  bcd
);
    localparam int CW = $clog2(W + 1);

    logic            run;
    logic [CW-1:0]   cnt;
    // {bcd accumulator, remaining binary bits}, shifted as one word.
    logic [15+W:0]   sr;
    logic [15:0]     adj;

    always_comb begin
        adj = sr[15+W -: 16];
        for (int i = 0; i < 4; i++) begin
            if (sr[W+4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = sr[W+4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            run <= 1'b0;
            cnt <= '0;
            sr  <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
            sr  <= {16'd0, bin};
        end else if (run) begin
            sr  <= {adj, sr[W-1:0]} << 1;
            cnt <= cnt + CW'(1);
            if (done) begin
                run <= 1'b0;
            end
        end
    end

    assign done = run && (cnt == CW'(W - 1));
    assign bcd  = sr[15+W -: 16];

endmodule

// File: rtl/score_seg_display.sv
// rtl/score_seg_display.sv - score to BCD conversion and 4-digit multiplexed 7-segment drive
// Ports: clk, clr_n (async active-low), upd (score_if.slave: score/score_valid/busy),
//        seg[6:0] (active-low g..a), an[3:0] (active-low one-hot, an[0]=ones), dp (always off).
// Option: SCORE_SEG_LZB_EN enables leading-zero blanking of digits 1..3.
module score_seg_display
    import seg7_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000,
    parameter int SCORE_W = 14
) (
    input  logic              clk,
    input  logic              clr_n,
    score_if.slave            upd,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              dp
);
    localparam int DIV_RAW = CLK_HZ / SCAN_HZ;
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int SW      = $clog2(DIV);
    localparam int IW      = $clog2(DIGITS);

    state_t             state, state_nx;
    logic               start, commit, done;
    logic               pending;
    logic [SCORE_W-1:0] pend_val, load_val, operand;
    logic [15:0]        conv_bcd, disp, disp_nx;
    logic [SW-1:0]      scan_cnt;
    logic [IW-1:0]      idx, idx_nx;
    logic [3:0]         digit;
    logic [6:0]         seg_nx;
    logic               blank;

    // A strobe in the same cycle as a load wins over the older pending value.
    assign load_val = upd.score_valid ? upd.score : pend_val;
    assign operand  = (32'(load_val) > 32'd9999) ? SCORE_W'(32'd9999) : load_val;
    assign upd.busy = (state != ST_IDLE);
    assign dp       = 1'b1;

    bin2bcd_seq #(.W(SCORE_W)) u_conv (
        .clk   (clk),
        .clr_n (clr_n),
        .start (start),
        .bin   (operand),
        .done  (done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // COMMIT restarts straight into CONV so busy never dips between back-to-back updates.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        commit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (upd.score_valid || pending) begin
                    start    = 1'b1;
                    state_nx = ST_CONV;
                end
            end
            ST_CONV: begin
                if (done) begin
                    state_nx = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit = 1'b1;
                if (upd.score_valid || pending) begin
                    start    = 1'b1;
                    state_nx = ST_CONV;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pending  <= 1'b0;
            pend_val <= '0;
        end else if (start) begin
            pending  <= 1'b0;
        end else if (upd.score_valid) begin
            pending  <= 1'b1;
            pend_val <= upd.score;
        end
    end

    // seg/an are registered from next-state values so a commit shows on the very next edge.
    assign disp_nx = commit ? conv_bcd : disp;
    assign idx_nx  = (scan_cnt == SW'(DIV - 1)) ? idx + IW'(1) : idx;
    assign digit   = disp_nx[{idx_nx, 2'b00} +: 4];

`ifdef SCORE_SEG_LZB_EN
    logic [15:0] upper;
    always_comb begin
        upper = disp_nx >> {idx_nx, 2'b00};
        blank = (idx_nx != '0) && (upper == 16'd0);
    end
`else
    assign blank = 1'b0;
`endif

    assign seg_nx = blank ? SEG_BLANK : seg_pattern(digit);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            disp     <= '0;
            scan_cnt <= '0;
            idx      <= '0;
            an       <= ~DIGITS'(1);
            seg      <= seg_pattern(4'd0);
        end else begin
            disp     <= disp_nx;
            scan_cnt <= (scan_cnt == SW'(DIV - 1)) ? '0 : scan_cnt + SW'(1);
            idx      <= idx_nx;
            an       <= ~(DIGITS'(1) << idx_nx);
            seg      <= seg_nx;
        end
    end

endmodule

// File: tb/tb_score_seg_display.sv
// tb/tb_score_seg_display.sv - self-checking bench for score_seg_display
module tb_score_seg_display;
    localparam int SW  = 14;
    localparam int DIV = 4;

    logic       clk   = 1'b0;
    logic       clr_n = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc;
    int prev;

    score_if #(.SCORE_W(SW)) u_if ();

    score_seg_display #(.CLK_HZ(4), .SCAN_HZ(1), .SCORE_W(SW)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .upd   (u_if.slave),
        .seg   (seg),
        .an    (an),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; the scanned digit is (edges / DIV) mod 4.
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int p10(input int k);
        case (k)
            0:       return 1;
            1:       return 10;
            2:       return 100;
            default: return 1000;
        endcase
    endfunction

    function automatic logic [6:0] digit_pat(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int k);
        int s;
        s = (v > 9999) ? 9999 : v;
`ifdef SCORE_SEG_LZB_EN
        if (k > 0 && s < p10(k)) return 7'b1111111;
`endif
        return digit_pat((s / p10(k)) % 10);
    endfunction

    task automatic check_scan(input string tag, input int v);
        int k;
        logic [3:0] ea;
        k  = (ncyc / DIV) % 4;
        ea = 4'b0001 << k;
        ea = ~ea;
        chk({tag, " an"}, an, ea);
        chk({tag, " seg"}, seg, exp_seg(v, k));
    endtask

    task automatic watch(input string tag, input int v, input int n);
        repeat (n) begin
            @(negedge clk);
            check_scan(tag, v);
            chk({tag, " dp"}, dp, 1'b1);
        end
    endtask

    task automatic strobe(input int v);
        @(negedge clk);
        u_if.score       = SW'(v);
        u_if.score_valid = 1'b1;
        @(negedge clk);
        u_if.score_valid = 1'b0;
    endtask

    // Strobe v; busy must hold for 15 cycles, the old value stays up to the commit,
    // and the new value appears 16 cycles after the strobe cycle.
    task automatic latency_run(input string tag, input int v, input int old);
        strobe(v);
        chk({tag, " busy c1"}, u_if.busy, 1'b1);
        for (int c = 2; c <= 15; c++) begin
            @(negedge clk);
            chk({tag, " busy"}, u_if.busy, 1'b1);
        end
        check_scan({tag, " pre-commit"}, old);
        @(negedge clk);
        chk({tag, " busy c16"}, u_if.busy, 1'b0);
        check_scan({tag, " c16"}, v);
        watch(tag, v, 4 * DIV);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        u_if.score       = '0;
        u_if.score_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst an", an, 4'b1110);
        chk("rst seg", seg, 7'b1000000);
        chk("rst dp", dp, 1'b1);
        chk("rst busy", u_if.busy, 1'b0);
        clr_n = 1'b1;
        watch("idle0", 0, 8);

        latency_run("2048", 2048, 0);
        latency_run("sat", 12345, 2048);
        latency_run("max", 9999, 9999);
        latency_run("sat10k", 10000, 9999);
        prev = 9999;

        // Back-to-back: 16, then 32 and 64 during CONV; 32 must never show.
        strobe(16);
        for (int c = 1; c <= 36; c++) begin
            if (c > 1) @(negedge clk);
            chk("b2b busy", u_if.busy, (c <= 30) ? 1'b1 : 1'b0);
            check_scan("b2b", (c < 16) ? prev : (c < 31) ? 16 : 64);
            u_if.score_valid = (c == 3 || c == 8);
            u_if.score       = (c == 3) ? SW'(32) : SW'(64);
        end
        u_if.score_valid = 1'b0;
        prev = 64;

        latency_run("seven", 7, prev);
        latency_run("zero", 0, 7);
        prev = 0;

        for (int i = 0; i < 6; i++) begin
            int v;
            v = $urandom_range(0, 16383);
            latency_run("rnd", v, prev);
            prev = v;
        end

        // Abort: reset at cycle 5 of a conversion, checked before any clock edge.
        strobe(5678);
        repeat (4) @(negedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        chk("abort an", an, 4'b1110);
        chk("abort seg", seg, 7'b1000000);
        chk("abort dp", dp, 1'b1);
        chk("abort busy", u_if.busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("abort idle busy", u_if.busy, 1'b0);
            check_scan("abort", 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
